// File: rtl/operand_sequencer.sv
// -----------------------------------------------------------------------------
// operand_sequencer
//
// Sits between register read and execute in the vector datapath. Decodes the
// incoming functype, picks op1/op2 from the vector, scalar, immediate, offset
// and PC sources, captures them into a VW-wide buffer, and then issues them to
// the execute stage as BEAT_LANES-wide beats. Vector ops (VADD, VDOT, SMUL)
// take NBEATS beats; scalar, address and jump ops take a single beat with the
// operand in lane 0 and the upper lanes zero. NOP and undefined opcodes are
// accepted and dropped. At most one request is in flight.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid / in_ready      request handshake (in_ready high only when idle)
//   functype                 opcode (VADD=0 .. J=8, NOP=15)
//   vectorData1/2            VW-bit vector sources
//   scalarData1/2            LANE_W-bit scalar sources
//   immediate, offset        8-bit immediate, 6-bit memory offset
//   PC                       LANE_W-bit program counter
//   out_valid / out_ready    beat handshake toward execute
//   out_functype             opcode of the beat being issued
//   out_op1 / out_op2        BW-bit operand beats
//   out_beat                 beat index (0 = lanes 0..BEAT_LANES-1)
//   out_last                 final beat of the request
// -----------------------------------------------------------------------------
module operand_sequencer #(
    parameter int LANES      = 16,
    parameter int LANE_W     = 16,
    parameter int BEAT_LANES = 4,
    localparam int VW     = LANES * LANE_W,
    localparam int BW     = BEAT_LANES * LANE_W,
    localparam int NBEATS = LANES / BEAT_LANES,
    localparam int IW     = (NBEATS > 1) ? $clog2(NBEATS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        functype,
    input  logic [VW-1:0]     vectorData1,
    input  logic [VW-1:0]     vectorData2,
    input  logic [LANE_W-1:0] scalarData1,
    input  logic [LANE_W-1:0] scalarData2,
    input  logic [7:0]        immediate,
    input  logic [5:0]        offset,
    input  logic [LANE_W-1:0] PC,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        out_functype,
    output logic [BW-1:0]     out_op1,
    output logic [BW-1:0]     out_op2,
    output logic [IW-1:0]     out_beat,
    output logic              out_last
);

    if (LANES % BEAT_LANES != 0) begin : g_bad_beat_lanes
        $error("operand_sequencer: LANES must be a multiple of BEAT_LANES");
    end

    localparam logic [3:0] FT_VADD = 4'd0;
    localparam logic [3:0] FT_VDOT = 4'd1;
    localparam logic [3:0] FT_SMUL = 4'd2;
    localparam logic [3:0] FT_SST  = 4'd3;
    localparam logic [3:0] FT_VLD  = 4'd4;
    localparam logic [3:0] FT_VST  = 4'd5;
    localparam logic [3:0] FT_SLL  = 4'd6;
    localparam logic [3:0] FT_SLH  = 4'd7;
    localparam logic [3:0] FT_J    = 4'd8;
    localparam logic [3:0] FT_NOP  = 4'hF;

    localparam logic [IW-1:0] LAST_VEC = IW'(NBEATS - 1);

    typedef enum logic {S_IDLE, S_ISSUE} state_t;

    state_t state_q, state_d;

    function automatic logic [LANE_W-1:0] sext_off(input logic signed [5:0] v);
        logic signed [LANE_W-1:0] ext;
        ext = LANE_W'(v);
        return ext;
    endfunction

    function automatic logic [LANE_W-1:0] sext_imm(input logic signed [7:0] v);
        logic signed [LANE_W-1:0] ext;
        ext = LANE_W'(v);
        return ext;
    endfunction

    function automatic logic [LANE_W-1:0] zext_imm(input logic [7:0] v);
        return LANE_W'(v);
    endfunction

    // Operand selection (combinational, consumed only at acceptance)
    logic [VW-1:0] sel_op1, sel_op2;
    logic [IW-1:0] sel_last;
    logic          sel_issue;

    always_comb begin
        sel_op1   = '0;
        sel_op2   = '0;
        sel_last  = '0;
        sel_issue = 1'b0;
        case (functype)
            FT_VADD, FT_VDOT: begin
                sel_op1   = vectorData1;
                sel_op2   = vectorData2;
                sel_last  = LAST_VEC;
                sel_issue = 1'b1;
            end
            FT_SMUL: begin
                sel_op1   = vectorData1;
                sel_op2   = {LANES{scalarData2}};
                sel_last  = LAST_VEC;
                sel_issue = 1'b1;
            end
            FT_SST, FT_VLD, FT_VST: begin
                sel_op1   = VW'(scalarData1);
                sel_op2   = VW'(sext_off(offset));
                sel_issue = 1'b1;
            end
            FT_SLL, FT_SLH: begin
                sel_op1   = VW'(scalarData1);
                sel_op2   = VW'(zext_imm(immediate));
                sel_issue = 1'b1;
            end
            FT_J: begin
                sel_op1   = VW'(PC);
                sel_op2   = VW'(sext_imm(immediate));
                sel_issue = 1'b1;
            end
            FT_NOP:  sel_issue = 1'b0;
            default: sel_issue = 1'b0;
        endcase
    end

    // Control FSM
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                // Dropped opcodes are still accepted; they just never leave IDLE.
                if (in_valid && sel_issue) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                out_valid = 1'b1;
                if (out_ready && out_last) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    logic          accept, advance;
    logic [IW-1:0] beat_nxt;
    int            nxt_base;

    always_comb begin
        accept   = (state_q == S_IDLE) && in_valid && sel_issue;
        advance  = (state_q == S_ISSUE) && out_ready;
        beat_nxt = out_beat + IW'(1);
        nxt_base = 32'(beat_nxt) * BW;
    end

    // Stage p0: captured request buffer
    logic [VW-1:0] buf_op1_p0, buf_op2_p0;
    logic [IW-1:0] last_p0;

    always_ff @(posedge clk) begin
        if (accept) begin
            buf_op1_p0 <= sel_op1;
            buf_op2_p0 <= sel_op2;
            last_p0    <= sel_last;
        end
    end

    // Stage p1: registered beat toward execute
    always_ff @(posedge clk) begin
        if (rst) begin
            out_functype <= FT_NOP;
            out_op1      <= '0;
            out_op2      <= '0;
            out_beat     <= '0;
            out_last     <= 1'b0;
        end else if (accept) begin
            out_functype <= functype;
            out_op1      <= sel_op1[BW-1:0];
            out_op2      <= sel_op2[BW-1:0];
            out_beat     <= '0;
            out_last     <= (sel_last == '0);
        end else if (advance) begin
            if (out_last) begin
                out_last <= 1'b0;
            end else begin
                out_op1  <= buf_op1_p0[nxt_base +: BW];
                out_op2  <= buf_op2_p0[nxt_base +: BW];
                out_beat <= beat_nxt;
                out_last <= (beat_nxt == last_p0);
            end
        end
    end

endmodule

// File: doc/operand_sequencer.md
Name: operand_sequencer

Overview:
- Parametrised successor to the combinational operand picker in the vector datapath: decodes functype, selects op1/op2, then registers them and issues them to the execute stage.
- Vector ops (VADD, VDOT, SMUL) are streamed as BEAT_LANES-wide beats over several cycles, so narrower functional units can be used.
- Scalar, address and jump ops issue as a single beat.
- Valid/ready handshake on both input and output sides; sits between register read and execute.

Parameters:
- LANES, 16, lanes per vector register.
- LANE_W, 16, bits per lane; also the scalar and PC width.
- BEAT_LANES, 4, lanes per output beat. LANES % BEAT_LANES must be 0, otherwise elaboration error.
- Derived: VW = LANES*LANE_W, BW = BEAT_LANES*LANE_W, NBEATS = LANES/BEAT_LANES, IW = max(1, clog2(NBEATS)).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  sequencer can accept a request
- functype  in  4  opcode: VADD=0, VDOT=1, SMUL=2, SST=3, VLD=4, VST=5, SLL=6, SLH=7, J=8, NOP=15
- vectorData1  in  VW  vector source 1
- vectorData2  in  VW  vector source 2
- scalarData1  in  LANE_W  scalar source 1
- scalarData2  in  LANE_W  scalar source 2
- immediate  in  8  immediate field
- offset  in  6  memory offset field
- PC  in  LANE_W  current PC
- out_valid  out  1  beat valid
- out_ready  in  1  execute stage accepts the beat
- out_functype  out  4  opcode of the current beat
- out_op1  out  BW  operand 1 beat
- out_op2  out  BW  operand 2 beat
- out_beat  out  IW  beat index; 0 = lanes 0..BEAT_LANES-1
- out_last  out  1  final beat of the request

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset: state=IDLE, in_ready=1, out_valid=0, out_last=0, out_beat=0, out_functype=4'hF, out_op1=0, out_op2=0.
- Reset mid-stream aborts the request; no further beats are issued.
- IDLE:
  - in_ready=1.
  - On in_valid, capture all inputs into an internal VW-wide op1/op2 buffer plus functype.
  - NOP or undefined functype: accept and drop; stay in IDLE; no beat issued.
  - Otherwise go to ISSUE with beat counter=0.
- ISSUE:
  - in_ready=0; out_valid=1.
  - Beat outputs come from registers; first beat is valid the cycle after acceptance (latency 1).
  - Beat k: out_op1/out_op2 = lanes k*BEAT_LANES .. k*BEAT_LANES+BEAT_LANES-1 of the buffer.
  - out_beat=k; out_last = (k == final beat).
  - On out_valid && out_ready: if last, go to IDLE (in_ready=1 the next cycle); else k+1.
- Backpressure: while out_ready=0, all out_* held stable.
- Input changes after acceptance have no effect.
- Operand selection at capture:
  - VADD, VDOT: op1=vectorData1, op2=vectorData2; NBEATS beats.
  - SMUL: op1=vectorData1; op2=scalarData2 broadcast into every lane; NBEATS beats.
  - VLD, VST, SST: op1=scalarData1; op2=offset sign-extended to LANE_W; 1 beat.
  - SLL, SLH: op1=scalarData1; op2=immediate zero-extended; 1 beat.
  - J: op1=PC; op2=immediate sign-extended; 1 beat.
  - All single-beat ops: operand in lane 0, lanes above 0 zero; out_beat=0, out_last=1.
- Throughput: at most one request in flight. A vector op with no backpressure occupies NBEATS cycles plus 1 idle cycle before the next accept.
- BEAT_LANES==LANES: every op is a single beat, out_last is always 1, out_beat is always 0.
- Simultaneous rst and in_valid: reset wins; the request is not accepted.

Test Plan:
- Reset with out_ready=1: out_valid=0, in_ready=1, out_functype=F, operands 0. After rst is released, still idle.
- VADD with defaults, lane i of vectorData1 = i, of vectorData2 = 16'h100+i, out_ready=1:
  - 4 consecutive beats, out_beat 0..3; out_last only on beat 3.
  - Beat 2: out_op1 lanes = 8,9,10,11; out_op2 lanes = 108..10B.
  - in_ready returns the cycle after beat 3.
- SMUL with scalarData2=16'h0003, out_ready toggling 1,0,0,1,...: each beat held while stalled; every out_op2 lane = 3; no beat skipped or duplicated.
- VLD offset=6'b111110, scalarData1=16'h1000: single beat; out_op1 lane0=1000; out_op2 lane0=FFFE; upper lanes 0; out_last=1.
- J immediate=8'h80, PC=16'h0040 (out_op2 lane0=FF80); SLL immediate=8'h80 (out_op2 lane0=0080); NOP: no out_valid, in_ready stays 1.
- Assert rst during beat 1 of a VDOT: next cycle IDLE, out_valid=0. A new VADD is then accepted and streams from beat 0.
